hazard_seq: RTL and testbench

HAZARD_SEQ -- requirements
Module: hazard_seq

---
 rtl/hazard_seq.sv | 126 ++++++++++++
 tb/tb_hazard_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_seq.sv
// Pipeline hazard sequencer: operand forwarding, load-use stalls, branch flushes
// and fixed-latency mul/div stalls, with a saturating stall-cycle counter.
module hazard_seq #(
  parameter int unsigned DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        MdStartE,
  input  logic        StatClr,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [15:0] StallCnt,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    MDWAIT = 2'd2
  } state_t;

  // The start cycle is the first of DIV_LAT stall cycles, so MDWAIT covers the rest.
  localparam logic [7:0] MD_LOAD = 8'(DIV_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wm, input logic [4:0] rdm,
                                         input logic       ww, input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs))      fwd_sel = 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs)) fwd_sel = 2'b01;
    else                                         fwd_sel = 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    case (state_q)
      BOOT: begin
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MdStartE) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          cnt_d   = MD_LOAD;
          state_d = MDWAIT;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MDWAIT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        cnt_d  = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StatClr)                                 stall_cnt_d = 16'd0;
    else if (StallF && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      cnt_q       <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt    = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_seq.sv
// Bench for hazard_seq: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_seq;

  localparam int unsigned DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE, StatClr;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCnt;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model state: in boot cycle, remaining mul/div wait cycles, stall count.
  bit m_boot     = 1'b1;
  int m_md_left  = 0;
  int m_stall_cnt = 0;

  hazard_seq #(.DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE), .StatClr(StatClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  function automatic logic [5:0] exp_ctrl();
    bit lw;
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (!reset || m_boot)  return 6'b000110;
    else if (m_md_left > 0) return 6'b111001;
    else if (PCSrcE)        return 6'b000110;
    else if (MdStartE)      return 6'b111001;
    else if (lw)            return 6'b110010;
    else                    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_md_left = 0;
    m_stall_cnt = 0;
  endtask

  task automatic model_clock();
    logic [5:0] e;
    e = exp_ctrl();
    if (!reset) begin
      model_reset();
    end else begin
      if (StatClr) m_stall_cnt = 0;
      else if (e[5] && m_stall_cnt < 65535) m_stall_cnt++;
      if (m_boot) m_boot = 1'b0;
      else if (m_md_left > 0) m_md_left--;
      else if (!PCSrcE && MdStartE) m_md_left = DIV_LAT - 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    check("ctrl", {10'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM}, {10'd0, exp_ctrl()});
    check("fwd", {12'd0, ForwardAE, ForwardBE}, {12'd0, exp_fwd(Rs1E), exp_fwd(Rs2E)});
    check("stallcnt", StallCnt, 16'(m_stall_cnt));
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE, StatClr} = '0;
  endtask

  task automatic randomize_inputs();
    Rs1D = 5'($urandom_range(0, 3));  Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3));  Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3));  RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    LoadE     = 1'($urandom_range(0, 1));
    PCSrcE    = ($urandom_range(0, 7) == 0);
    MdStartE  = ($urandom_range(0, 9) == 0);
    StatClr   = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    clear_inputs();
    model_reset();

    // Held in reset: boot outputs, forwarding still live.
    RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
    step();
    step();
    clear_inputs();
    reset = 1'b1;
    step();                       // BOOT cycle
    step();                       // RUN, idle

    // Load-use stall for one cycle, then none when RdE is x0.
    LoadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
    step();
    LoadE = 1'b0;
    step();
    LoadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
    step();
    clear_inputs();

    // Taken branch overrides both load-use and mul/div start.
    PCSrcE = 1'b1; MdStartE = 1'b1; LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    step();
    clear_inputs();
    step();

    // Single mul/div op with a branch pulse in the middle of the wait.
    MdStartE = 1'b1;
    step();
    MdStartE = 1'b0;
    step();
    PCSrcE = 1'b1;
    step();
    PCSrcE = 1'b0;
    repeat (3) step();

    // Back-to-back mul/div ops.
    MdStartE = 1'b1;
    repeat (2 * DIV_LAT + 2) step();
    MdStartE = 1'b0;
    step();

    // Forwarding priority: Memory over Writeback over register file.
    RegWriteM = 1'b1; RdM = 5'd7; RegWriteW = 1'b1; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
    step();
    RegWriteM = 1'b0;
    step();
    RdW = 5'd0;
    step();
    clear_inputs();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        model_reset();
        step();
        reset = 1'b1;
      end
      step();
    end
    clear_inputs();
    StatClr = 1'b1;
    step();
    StatClr = 1'b0;

    // Long continuous load-use stall drives the counter into saturation.
    LoadE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    repeat (70000) step();
    check("stallcnt_sat", StallCnt, 16'hFFFF);
    LoadE = 1'b0;
    StatClr = 1'b1;
    step();
    StatClr = 1'b0;
    step();

    // Reset during the second MDWAIT cycle abandons the wait.
    MdStartE = 1'b1;
    step();
    MdStartE = 1'b0;
    step();                       // first MDWAIT cycle
    reset = 1'b0;
    model_reset();
    #1;
    check("async_reset_ctrl", {10'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM}, 16'b000110);
    check("async_reset_cnt", StallCnt, 16'd0);
    step();
    reset = 1'b1;
    step();                       // BOOT
    step();                       // RUN, no stall
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
